// File: rtl/sik_pkg.sv
// Shared definitions for the SIK stack core: instruction word width,
// opcode constants (normal and extended), NOARG / NOOP encodings and the
// thread-id type used by the multi-threaded front end.
package sik_pkg;

    localparam int WORD = 16;
    localparam int TID_MAX_W = 4;

    // Thread-id type wide enough for the largest supported thread count (16).
    typedef logic [TID_MAX_W-1:0] tid_t;

    // Normal opcodes live in the top nibble of the instruction word.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;
    localparam logic [3:0] OP_EXT  = 4'hF;

    // Extended opcodes sit in the next nibble when the top nibble is OP_EXT.
    localparam logic [3:0] XOP_DUP  = 4'h0;
    localparam logic [3:0] XOP_SWAP = 4'h1;
    localparam logic [3:0] XOP_OVER = 4'h2;

    // Argument field value meaning "no operand", and the canonical no-op word.
    localparam logic [WORD-5:0] NOARG = '0;
    localparam logic [WORD-1:0] NOOP  = {OP_NOP, NOARG};

    // Major opcode of an instruction word.
    function automatic logic [3:0] opcode_of(input logic [WORD-1:0] w);
        return w[WORD-1:WORD-4];
    endfunction

endpackage

// File: rtl/sik_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester
// strictly after the pointer, wrapping modulo N.
module sik_rr_arbiter
    import sik_pkg::*;
#(
    parameter int N     = 2,
    parameter int TID_W = 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [TID_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [TID_W-1:0] sel,
    output logic             any_grant
);

    // Scan requesters in rotation order starting just after the pointer.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        sel       = '0;
        any_grant = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && eligible[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                sel        = TID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sik_thread_issue.sv
// N-thread barrel fetch/issue front end for the SIK stack core.
// Round-robin selects one eligible thread per cycle, fetches at its PC and
// registers the tagged instruction for decode. Supports per-thread halt,
// branch redirect and a stall from decode.
// Optional macro SIK_ISSUE_PERF_EN adds per-thread issue counters and a
// bubble counter.
module sik_thread_issue
    import sik_pkg::*;
#(
    parameter int NTHREADS = 2,
    parameter int TID_W    = 1,
    parameter int ADDR_W   = 16,
    parameter int WORD_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [WORD_W-1:0]   imem_data,
    input  logic                stall,
    output logic                issue_valid,
    output logic [WORD_W-1:0]   issue_inst,
    output logic [TID_W-1:0]    issue_tid,
    output logic [ADDR_W-1:0]   issue_pc,
    input  logic                redirect_valid,
    input  logic [TID_W-1:0]    redirect_tid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt_valid,
    input  logic [TID_W-1:0]    halt_tid,
    output logic [NTHREADS-1:0] thread_halted,
    output logic                halted
`ifdef SIK_ISSUE_PERF_EN
    ,
    output logic [NTHREADS*16-1:0] perf_issue_cnt,
    output logic [15:0]            perf_bubble_cnt
`endif
);

    logic [ADDR_W-1:0]   pc [NTHREADS];
    logic [NTHREADS-1:0] redir_hit;
    logic [NTHREADS-1:0] halt_hit;
    logic [NTHREADS-1:0] eligible;
    logic [NTHREADS-1:0] grant;
    logic [TID_W-1:0]    sel;
    logic                any_grant;
    logic                do_issue;
    logic [TID_W-1:0]    ptr_reg;

    genvar gi;

    generate
        for (gi = 0; gi < NTHREADS; gi++) begin : g_thread
            logic [ADDR_W-1:0] pc_reg;
            logic              halt_reg;

            // Out-of-range tids never match any thread, so they are ignored.
            assign redir_hit[gi] = redirect_valid && (redirect_tid == TID_W'(gi));
            assign halt_hit[gi]  = halt_valid && (halt_tid == TID_W'(gi));
            assign eligible[gi]  = !halt_reg && !redir_hit[gi] && !halt_hit[gi];

            // PC: halt beats redirect; redirect beats issue (a redirected thread is never granted).
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pc_reg <= ADDR_W'(gi);
                end else if (halt_hit[gi]) begin
                    pc_reg <= pc_reg;
                end else if (redir_hit[gi]) begin
                    pc_reg <= redirect_pc;
                end else if (do_issue && grant[gi]) begin
                    pc_reg <= pc_reg + ADDR_W'(NTHREADS);
                end
            end

            // Sticky halt flag, set even while decode stalls.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    halt_reg <= 1'b0;
                end else if (halt_hit[gi]) begin
                    halt_reg <= 1'b1;
                end
            end

            assign pc[gi]            = pc_reg;
            assign thread_halted[gi] = halt_reg;
        end
    endgenerate

    sik_rr_arbiter #(
        .N     (NTHREADS),
        .TID_W (TID_W)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_reg),
        .grant     (grant),
        .sel       (sel),
        .any_grant (any_grant)
    );

    assign imem_addr = pc[sel];
    assign do_issue  = !stall && any_grant;

    // Issue register and RR pointer; frozen entirely while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid <= 1'b0;
            issue_inst  <= '0;
            issue_tid   <= '0;
            issue_pc    <= '0;
            ptr_reg     <= TID_W'(NTHREADS - 1);
        end else if (!stall) begin
            if (any_grant) begin
                issue_valid <= 1'b1;
                issue_inst  <= imem_data;
                issue_tid   <= sel;
                issue_pc    <= pc[sel];
                ptr_reg     <= sel;
            end else begin
                issue_valid <= 1'b0;
            end
        end
    end

    // All-halted flag includes the halt landing this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted <= 1'b0;
        end else begin
            halted <= &(thread_halted | halt_hit);
        end
    end

`ifdef SIK_ISSUE_PERF_EN
    generate
        for (gi = 0; gi < NTHREADS; gi++) begin : g_perf
            logic [15:0] cnt_reg;

            // Saturating count of instructions issued by this thread.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (do_issue && grant[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end

            assign perf_issue_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate

    logic [15:0] bubble_reg;

    // Saturating count of non-stalled cycles where nothing could issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_reg <= '0;
        end else if (!stall && !any_grant && bubble_reg != 16'hFFFF) begin
            bubble_reg <= bubble_reg + 16'd1;
        end
    end

    assign perf_bubble_cnt = bubble_reg;
`else
    // Performance counters not built.
`endif

endmodule

// File: doc/sik_thread_issue.md
Name: sik_thread_issue

Overview:
- Parametrised N-thread barrel fetch/issue front end for the SIK stack core.
- Generalises the fixed two-PC, counter-alternated fetch into a round-robin issue unit.
- Adds per-thread halt, per-thread branch redirect and back-pressure.
- Sits between instruction memory and the decode stage; emits one tagged instruction per cycle.

Parameters:
- NTHREADS, 2, number of hardware threads (1..16).
- TID_W, 1, thread-id width; must satisfy 2**TID_W >= NTHREADS.
- ADDR_W, 16, PC / instruction address width.
- WORD_W, 16, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  instruction fetch address; combinational from the selected thread's PC.
- imem_data  in  WORD_W  instruction at imem_addr, valid in the same cycle.
- stall  in  1  decode cannot accept; freeze issue.
- issue_valid  out  1  issue_inst / issue_tid / issue_pc are valid.
- issue_inst  out  WORD_W  issued instruction.
- issue_tid  out  TID_W  owning thread.
- issue_pc  out  ADDR_W  PC the instruction was fetched from.
- redirect_valid  in  1  load a new PC for redirect_tid.
- redirect_tid  in  TID_W  thread to redirect.
- redirect_pc  in  ADDR_W  new PC.
- halt_valid  in  1  mark halt_tid halted.
- halt_tid  in  TID_W  thread to halt.
- thread_halted  out  NTHREADS  per-thread halted flags, registered.
- halted  out  1  all threads halted, registered.

Behaviour:
- Reset (async assert):
  - pc[t] = t; thread_halted = 0; halted = 0.
  - issue_valid = 0; issue_inst = 0; issue_tid = 0; issue_pc = 0.
  - RR pointer = NTHREADS-1, so thread 0 issues first.
- Eligibility: thread t is eligible when all of the following hold:
  - it is not halted;
  - it is not the target of redirect_valid this cycle;
  - it is not the target of halt_valid this cycle.
- Selection: first eligible thread strictly after the RR pointer, modulo NTHREADS.
- Issue cycle (stall = 0, some thread eligible), at the clock edge:
  - issue regs <= {1, imem_data, sel, pc[sel]};
  - pc[sel] <= pc[sel] + NTHREADS, wrapping modulo 2**ADDR_W;
  - RR pointer <= sel.
  - Latency: 1 cycle from address to issue_valid.
- No eligible thread, stall = 0: issue_valid <= 0; no PC or pointer change.
- stall = 1:
  - issue regs, pointer and all PCs hold, except redirect/halt targets.
  - issue_valid holds its value.
- Redirect: pc[redirect_tid] <= redirect_pc; applied even under stall.
- Halt: thread_halted[halt_tid] <= 1, sticky until reset; applied even under stall.
- Halt and redirect to the same tid in the same cycle: halt wins and the PC is unchanged.
- Out-of-range tid (>= NTHREADS) on redirect or halt: ignored.
- halted <= 1 when every thread_halted bit is set, counting the halt being applied this cycle; it asserts at the same edge as the last thread_halted bit.
- NTHREADS = 1: pointer logic degenerates, the thread issues every non-stalled cycle, and the PC step is 1.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: SIK_ISSUE_PERF_EN.
- Defined:
  - adds output perf_issue_cnt (NTHREADS*16): per-thread saturating count of issued instructions;
  - adds output perf_bubble_cnt (16): saturating count of non-stalled cycles with no eligible thread;
  - both counters cleared by reset.
- Undefined: ports and counters are absent; the behaviour described above is unchanged.

Decomposition:
- Package sik_pkg holds:
  - WORD width, opcode constants (normal and extended), NOARG and NOOP encodings;
  - the thread-id typedef.
- One sub-module: sik_rr_arbiter.
  - Inputs: eligible vector and pointer; outputs: one-hot grant, encoded sel and any_grant.
  - Purely combinational; instantiated once.

Test Plan:
- Reset, NTHREADS=2, no stall, 6 cycles:
  - issue sequence (tid, pc) = (0,0), (1,1), (0,2), (1,3), (0,4), (1,5);
  - imem_addr matches each issued pc one cycle earlier.
- NTHREADS=4, halt_tid=2 asserted on cycle 3:
  - thread 2 is never issued again;
  - rotation becomes 0, 1, 3, 0, 1, 3;
  - thread_halted = 4'b0100 one edge later.
- Redirect tid=1 to pc 0x0100 on the cycle thread 1 would be selected:
  - thread 1 is skipped that cycle;
  - its next issue has issue_pc = 0x0100, then 0x0102 (NTHREADS=2).
- stall held for 3 cycles mid-stream:
  - issue_inst, issue_tid, issue_pc and issue_valid are frozen;
  - after release the stream continues with no lost or duplicated pc;
  - a redirect during the stall still takes effect.
- Halt threads 0 and 1 in consecutive cycles:
  - halted rises at the edge the second halt applies;
  - issue_valid drops to 0 afterwards.
- pc[0] = 0xFFFE with NTHREADS=2:
  - next issue pc is 0x0000 (wrap);
  - async reset asserted between edges clears issue_valid immediately.
